// File: rtl/pip_debug_pkg.sv
// Shared types and constants for the PRV664 core-side debug responder.
// XLEN is the core data width used by every debug data path.
package pip_debug_pkg;

  localparam int unsigned XLEN = 64;

  typedef enum logic [1:0] {
    RUNNING  = 2'd0,
    DRAINING = 2'd1,
    HALTED   = 2'd2,
    RESUMING = 2'd3
  } dbg_state_t;

  localparam logic DBG_RESET_RUN = 1'b1;

endpackage

// File: rtl/pipdebug_interface.sv
// Debug channel between the debug module (master) and the core responder (slave).
interface pipdebug_interface;
  import pip_debug_pkg::*;

  logic [11:0]     csrindex;
  logic            csrwr;
  logic [XLEN-1:0] csrwdata;
  logic [XLEN-1:0] csrrdata;
  logic [4:0]      igprindex;
  logic            igprwr;
  logic [XLEN-1:0] igprwdata;
  logic [XLEN-1:0] igprrdata;
  logic [4:0]      fgprindex;
  logic            fgprwr;
  logic [XLEN-1:0] fgprwdata;
  logic [XLEN-1:0] fgprrdata;
  logic            haltreq;
  logic            halted;
  logic            resumereq;
  logic            run;

  modport master (
    output csrindex, csrwr, csrwdata, igprindex, igprwr, igprwdata,
    output fgprindex, fgprwr, fgprwdata, haltreq, resumereq,
    input  csrrdata, igprrdata, fgprrdata, halted, run
  );

  modport slave (
    input  csrindex, csrwr, csrwdata, igprindex, igprwr, igprwdata,
    input  fgprindex, fgprwr, fgprwdata, haltreq, resumereq,
    output csrrdata, igprrdata, fgprrdata, halted, run
  );

endinterface

// File: rtl/pip_debug_regport.sv
// One debug register-file port: write enable gated by the halted flag and a
// read-return register that only holds data while halted.
module pip_debug_regport
  import pip_debug_pkg::*;
#(
  parameter int unsigned Width = XLEN
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             halted_i,
  input  logic             wr_i,
  input  logic [Width-1:0] rdata_i,
  output logic             wr_o,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] rdata_d, rdata_q;

  assign wr_o = wr_i & halted_i;

  always_comb begin
    rdata_d = '0;
    if (halted_i) rdata_d = rdata_i;
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) rdata_q <= '0;
    else           rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pip_debug_resp.sv
// Core-side debug responder: halt/resume FSM plus halted-only register access.
// Define PRV664_DEBUG_FPR_EN to implement the FP-GPR access path.
module pip_debug_resp
  import pip_debug_pkg::*;
(
  input  logic              clk_i,
  input  logic              arst_n_i,
  pipdebug_interface.slave  dbg,
  output logic              pip_halt_o,
  input  logic              pip_idle_i,
  output logic              pip_resume_o,
  output logic [11:0]       csr_index_o,
  output logic              csr_wr_o,
  output logic [XLEN-1:0]   csr_wdata_o,
  input  logic [XLEN-1:0]   csr_rdata_i,
  output logic [4:0]        igpr_index_o,
  output logic              igpr_wr_o,
  output logic [XLEN-1:0]   igpr_wdata_o,
  input  logic [XLEN-1:0]   igpr_rdata_i,
  output logic [4:0]        fgpr_index_o,
  output logic              fgpr_wr_o,
  output logic [XLEN-1:0]   fgpr_wdata_o,
  input  logic [XLEN-1:0]   fgpr_rdata_i
);

  dbg_state_t state_d, state_q;
  logic halted_q, run_q, halt_q, resume_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUNNING:  if (dbg.haltreq)   state_d = DRAINING;
      DRAINING: if (pip_idle_i)    state_d = HALTED;
      HALTED:   if (dbg.resumereq) state_d = RESUMING;
      RESUMING:                    state_d = RUNNING;
    endcase
  end

  // Status outputs are flopped from the next state so they track state_q exactly.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q  <= RUNNING;
      halted_q <= 1'b0;
      run_q    <= DBG_RESET_RUN;
      halt_q   <= 1'b0;
      resume_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= (state_d == HALTED);
      run_q    <= (state_d == RUNNING);
      halt_q   <= (state_d == DRAINING) || (state_d == HALTED);
      resume_q <= (state_d == RESUMING);
    end
  end

  assign dbg.halted   = halted_q;
  assign dbg.run      = run_q;
  assign pip_halt_o   = halt_q;
  assign pip_resume_o = resume_q;

  assign csr_index_o  = dbg.csrindex;
  assign csr_wdata_o  = dbg.csrwdata;
  assign igpr_index_o = dbg.igprindex;
  assign igpr_wdata_o = dbg.igprwdata;

  pip_debug_regport #(.Width(XLEN)) u_csr_port (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .halted_i (halted_q),
    .wr_i     (dbg.csrwr),
    .rdata_i  (csr_rdata_i),
    .wr_o     (csr_wr_o),
    .rdata_o  (dbg.csrrdata)
  );

  pip_debug_regport #(.Width(XLEN)) u_igpr_port (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .halted_i (halted_q),
    .wr_i     (dbg.igprwr),
    .rdata_i  (igpr_rdata_i),
    .wr_o     (igpr_wr_o),
    .rdata_o  (dbg.igprrdata)
  );

`ifdef PRV664_DEBUG_FPR_EN
  assign fgpr_index_o = dbg.fgprindex;
  assign fgpr_wdata_o = dbg.fgprwdata;

  pip_debug_regport #(.Width(XLEN)) u_fgpr_port (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .halted_i (halted_q),
    .wr_i     (dbg.fgprwr),
    .rdata_i  (fgpr_rdata_i),
    .wr_o     (fgpr_wr_o),
    .rdata_o  (dbg.fgprrdata)
  );
`else
  logic unused_fgpr;
  assign unused_fgpr   = ^{fgpr_rdata_i, dbg.fgprwr, dbg.fgprindex, dbg.fgprwdata};
  assign fgpr_index_o  = '0;
  assign fgpr_wdata_o  = '0;
  assign fgpr_wr_o     = 1'b0;
  assign dbg.fgprrdata = '0;
`endif

endmodule

// File: tb/tb_pip_debug_resp.sv
// Self-checking bench for pip_debug_resp: halt/resume handshake, gated access, resets.
module tb_pip_debug_resp;
  import pip_debug_pkg::*;

`ifdef PRV664_DEBUG_FPR_EN
  localparam bit FprOn = 1'b1;
`else
  localparam bit FprOn = 1'b0;
`endif

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  pipdebug_interface dbg_if ();

  logic            pip_halt, pip_idle, pip_resume;
  logic [11:0]     csr_index;
  logic            csr_wr;
  logic [XLEN-1:0] csr_wdata, csr_rdata;
  logic [4:0]      igpr_index, fgpr_index;
  logic            igpr_wr, fgpr_wr;
  logic [XLEN-1:0] igpr_wdata, igpr_rdata, fgpr_wdata, fgpr_rdata;

  pip_debug_resp dut (
    .clk_i        (clk),
    .arst_n_i     (arst_n),
    .dbg          (dbg_if),
    .pip_halt_o   (pip_halt),
    .pip_idle_i   (pip_idle),
    .pip_resume_o (pip_resume),
    .csr_index_o  (csr_index),
    .csr_wr_o     (csr_wr),
    .csr_wdata_o  (csr_wdata),
    .csr_rdata_i  (csr_rdata),
    .igpr_index_o (igpr_index),
    .igpr_wr_o    (igpr_wr),
    .igpr_wdata_o (igpr_wdata),
    .igpr_rdata_i (igpr_rdata),
    .fgpr_index_o (fgpr_index),
    .fgpr_wr_o    (fgpr_wr),
    .fgpr_wdata_o (fgpr_wdata),
    .fgpr_rdata_i (fgpr_rdata)
  );

  typedef struct {
    logic        csrwr;
    logic [11:0] csrindex;
    logic [63:0] csrwdata;
    logic [63:0] csr_rd;
    logic        igprwr;
    logic [4:0]  igprindex;
    logic [63:0] igprwdata;
    logic [63:0] igpr_rd;
    logic        fgprwr;
    logic [4:0]  fgprindex;
    logic [63:0] fgprwdata;
    logic [63:0] fgpr_rd;
  } vec_t;

  typedef struct {
    logic [63:0] csr;
    logic [63:0] igpr;
    logic [63:0] fgpr;
  } exp_t;

  vec_t vecs[4];
  exp_t sb[$];
  exp_t e;
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clr_inputs();
    dbg_if.csrindex  = '0; dbg_if.csrwr  = 1'b0; dbg_if.csrwdata  = '0;
    dbg_if.igprindex = '0; dbg_if.igprwr = 1'b0; dbg_if.igprwdata = '0;
    dbg_if.fgprindex = '0; dbg_if.fgprwr = 1'b0; dbg_if.fgprwdata = '0;
    dbg_if.haltreq   = 1'b0; dbg_if.resumereq = 1'b0;
    csr_rdata = '0; igpr_rdata = '0; fgpr_rdata = '0;
    pip_idle = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_halted"}, 64'(dbg_if.halted), 64'd0);
    chk({tag, "_run"}, 64'(dbg_if.run), 64'd1);
    chk({tag, "_pip_halt"}, 64'(pip_halt), 64'd0);
    chk({tag, "_pip_resume"}, 64'(pip_resume), 64'd0);
    chk({tag, "_csrrdata"}, dbg_if.csrrdata, 64'd0);
    chk({tag, "_igprrdata"}, dbg_if.igprrdata, 64'd0);
    chk({tag, "_fgprrdata"}, dbg_if.fgprrdata, 64'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 12'h341, 64'hDEAD_BEEF, 64'h1111, 1'b0, 5'd10, 64'h0, 64'h1234,
                1'b1, 5'd3, 64'h55, 64'hABCD};
    vecs[1] = '{1'b0, 12'h300, 64'h0, 64'h8000_0000_0000_1800, 1'b1, 5'd31, '1, 64'h0,
                1'b0, 5'd0, 64'h0, '1};
    vecs[2] = '{1'b1, 12'h7B0, 64'h4003, 64'h4003, 1'b1, 5'd1, 64'h8000_0000,
                64'h8000_0000_0000_0000, 1'b1, 5'd31, 64'h77, 64'h1};
    vecs[3] = '{1'b0, 12'h000, 64'h0, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0, 5'd0, 64'h0,
                64'h5A5A_5A5A_5A5A_5A5A, 1'b0, 5'd0, 64'h0, 64'h3C3C};

    clr_inputs();
    #12;
    chk_reset_vals("reset");
    arst_n = 1'b1;
    step();

    // Writes while running must be dropped.
    dbg_if.csrwr = 1'b1; dbg_if.csrindex = 12'h341; dbg_if.csrwdata = 64'hDEAD_BEEF;
    dbg_if.igprwr = 1'b1; csr_rdata = 64'h77;
    #1;
    chk("run_csr_wr", 64'(csr_wr), 64'd0);
    chk("run_igpr_wr", 64'(igpr_wr), 64'd0);
    chk("run_csr_index", 64'(csr_index), 64'h341);
    step();
    chk("run_csrrdata", dbg_if.csrrdata, 64'd0);
    clr_inputs();

    // Halt handshake with five idle-low cycles.
    dbg_if.haltreq = 1'b1;
    #1;
    chk("c0_run", 64'(dbg_if.run), 64'd1);
    step();
    chk("c1_run", 64'(dbg_if.run), 64'd0);
    chk("c1_pip_halt", 64'(pip_halt), 64'd1);
    for (int c = 1; c <= 6; c++) begin
      if (c == 6) pip_idle = 1'b1;
      #1;
      chk($sformatf("c%0d_halted", c), 64'(dbg_if.halted), 64'd0);
      step();
    end
    chk("c7_halted", 64'(dbg_if.halted), 64'd1);
    chk("c7_pip_halt", 64'(pip_halt), 64'd1);
    dbg_if.haltreq = 1'b0;

    for (int i = 0; i < 4; i++) begin
      dbg_if.csrwr = vecs[i].csrwr; dbg_if.csrindex = vecs[i].csrindex;
      dbg_if.csrwdata = vecs[i].csrwdata; csr_rdata = vecs[i].csr_rd;
      dbg_if.igprwr = vecs[i].igprwr; dbg_if.igprindex = vecs[i].igprindex;
      dbg_if.igprwdata = vecs[i].igprwdata; igpr_rdata = vecs[i].igpr_rd;
      dbg_if.fgprwr = vecs[i].fgprwr; dbg_if.fgprindex = vecs[i].fgprindex;
      dbg_if.fgprwdata = vecs[i].fgprwdata; fgpr_rdata = vecs[i].fgpr_rd;
      sb.push_back('{vecs[i].csr_rd, vecs[i].igpr_rd, FprOn ? vecs[i].fgpr_rd : 64'd0});
      #1;
      chk($sformatf("v%0d_csr_wr", i), 64'(csr_wr), 64'(vecs[i].csrwr));
      chk($sformatf("v%0d_csr_index", i), 64'(csr_index), 64'(vecs[i].csrindex));
      chk($sformatf("v%0d_csr_wdata", i), csr_wdata, vecs[i].csrwdata);
      chk($sformatf("v%0d_igpr_wr", i), 64'(igpr_wr), 64'(vecs[i].igprwr));
      chk($sformatf("v%0d_igpr_index", i), 64'(igpr_index), 64'(vecs[i].igprindex));
      chk($sformatf("v%0d_igpr_wdata", i), igpr_wdata, vecs[i].igprwdata);
      chk($sformatf("v%0d_fgpr_wr", i), 64'(fgpr_wr), 64'(FprOn & vecs[i].fgprwr));
      chk($sformatf("v%0d_fgpr_index", i), 64'(fgpr_index),
          FprOn ? 64'(vecs[i].fgprindex) : 64'd0);
      chk($sformatf("v%0d_fgpr_wdata", i), fgpr_wdata, FprOn ? vecs[i].fgprwdata : 64'd0);
      step();
      e = sb.pop_front();
      chk($sformatf("v%0d_csrrdata", i), dbg_if.csrrdata, e.csr);
      chk($sformatf("v%0d_igprrdata", i), dbg_if.igprrdata, e.igpr);
      chk($sformatf("v%0d_fgprrdata", i), dbg_if.fgprrdata, e.fgpr);
    end
    clr_inputs();

    // Resume with haltreq held; a write in the resume cycle still lands.
    dbg_if.resumereq = 1'b1; dbg_if.haltreq = 1'b1;
    dbg_if.igprindex = 5'd10; igpr_rdata = 64'h1234; dbg_if.csrwr = 1'b1;
    #1;
    chk("k_csr_wr", 64'(csr_wr), 64'd1);
    step();
    chk("k1_pip_resume", 64'(pip_resume), 64'd1);
    chk("k1_halted", 64'(dbg_if.halted), 64'd0);
    chk("k1_pip_halt", 64'(pip_halt), 64'd0);
    chk("k1_run", 64'(dbg_if.run), 64'd0);
    chk("k1_igprrdata", dbg_if.igprrdata, 64'h1234);
    chk("k1_csr_wr", 64'(csr_wr), 64'd0);
    step();
    chk("k2_pip_resume", 64'(pip_resume), 64'd0);
    chk("k2_run", 64'(dbg_if.run), 64'd1);
    chk("k2_igprrdata", dbg_if.igprrdata, 64'd0);
    dbg_if.resumereq = 1'b0;
    step();
    chk("k3_pip_halt", 64'(pip_halt), 64'd1);
    chk("k3_run", 64'(dbg_if.run), 64'd0);
    chk("k3_halted", 64'(dbg_if.halted), 64'd0);

    // Asynchronous reset while draining.
    #1 arst_n = 1'b0;
    #1 chk_reset_vals("rst_drain");
    dbg_if.haltreq = 1'b0;
    #1 arst_n = 1'b1;
    step();
    clr_inputs();

    // Minimum halt latency with idle already high.
    dbg_if.haltreq = 1'b1; pip_idle = 1'b1;
    step();
    chk("min1_halted", 64'(dbg_if.halted), 64'd0);
    chk("min1_pip_halt", 64'(pip_halt), 64'd1);
    step();
    chk("min2_halted", 64'(dbg_if.halted), 64'd1);
    dbg_if.haltreq = 1'b0;

    // Read data held while halted must clear asynchronously on reset.
    igpr_rdata = 64'hCAFE; csr_rdata = 64'h5; fgpr_rdata = 64'h99;
    step();
    chk("hold_igprrdata", dbg_if.igprrdata, 64'hCAFE);
    chk("hold_csrrdata", dbg_if.csrrdata, 64'h5);
    chk("hold_fgprrdata", dbg_if.fgprrdata, FprOn ? 64'h99 : 64'd0);
    #1 arst_n = 1'b0;
    #1 chk_reset_vals("rst_halted");
    #1 arst_n = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
